// File: rtl/mult_sequencer.sv
// Shift-and-add sequencer for a signed multiply; it steers three external 28-bit registers.
// Optional macro MULT_SEQ_EARLY_EXIT_EN ends the iteration loop as soon as the multiplier register reaches zero.
module mult_sequencer #(
  parameter int OPERAND_WIDTH = 14
) (
  input  logic                            clockSequencer,
  input  logic                            resetSequencer,
  input  logic                            start,
  input  logic signed [OPERAND_WIDTH-1:0] operandA,
  input  logic signed [OPERAND_WIDTH-1:0] operandB,
  input  logic [27:0]                     multiplicandValue,
  input  logic [27:0]                     multiplierValue,
  input  logic [27:0]                     productValue,
  output logic [2:0]                      cmdMultiplicand,
  output logic [2:0]                      cmdMultiplier,
  output logic [2:0]                      cmdProduct,
  output logic [27:0]                     loadMultiplicand,
  output logic [27:0]                     loadMultiplier,
  output logic [27:0]                     sumOut,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'b000,
    CMD_RESET = 3'b001,
    CMD_LOAD  = 3'b010,
    CMD_SHL   = 3'b011,
    CMD_SHR   = 3'b100
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_SIGN, S_DONE
  } state_e;

  localparam logic [3:0]               LAST_ITER = 4'(OPERAND_WIDTH - 1);
  localparam logic [OPERAND_WIDTH-1:0] ONE       = OPERAND_WIDTH'(1);

  state_e                   state, next_state;
  logic [3:0]               counter;
  logic                     sign_q;
  logic [OPERAND_WIDTH-1:0] op_a_q, op_b_q;
  cmd_e                     cmd_mc_d, cmd_mp_d, cmd_pr_d;

  // |-2^(W-1)| still fits because the result is treated as W-bit unsigned.
  function automatic logic [27:0] magnitude(input logic [OPERAND_WIDTH-1:0] v);
    logic [OPERAND_WIDTH-1:0] m;
    m = v[OPERAND_WIDTH-1] ? (~v + ONE) : v;
    return {{(28 - OPERAND_WIDTH){1'b0}}, m};
  endfunction

  assign loadMultiplicand = magnitude(op_a_q);
  assign loadMultiplier   = magnitude(op_b_q);
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);

  always_comb begin
    sumOut = productValue + multiplicandValue;
    if (state == S_SIGN && sign_q) sumOut = 28'd0 - productValue;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_TEST;
      S_TEST: begin
        next_state = multiplierValue[0] ? S_ADD : S_SHIFT;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if (multiplierValue == 28'd0) next_state = S_SIGN;
`else
        // Only bit 0 steers the loop when every iteration runs.
`endif
      end
      S_ADD:   next_state = S_SHIFT;
      S_SHIFT: next_state = (counter == LAST_ITER) ? S_SIGN : S_TEST;
      S_SIGN:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    // Commands are decoded from the state being entered so they register in step with it.
    cmd_mc_d = CMD_HOLD;
    cmd_mp_d = CMD_HOLD;
    cmd_pr_d = CMD_HOLD;
    case (next_state)
      S_LOAD: begin
        cmd_mc_d = CMD_LOAD;
        cmd_mp_d = CMD_LOAD;
        cmd_pr_d = CMD_RESET;
      end
      S_ADD:   cmd_pr_d = CMD_LOAD;
      S_SHIFT: begin
        cmd_mc_d = CMD_SHL;
        cmd_mp_d = CMD_SHR;
      end
      S_SIGN:  if (sign_q) cmd_pr_d = CMD_LOAD;
      default: ;
    endcase
  end

`ifndef MULT_SEQ_EARLY_EXIT_EN
  logic unused_multiplier_bits;
  assign unused_multiplier_bits = ^multiplierValue[27:1];
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clockSequencer or posedge resetSequencer) begin
    if (resetSequencer) begin
      state           <= S_IDLE;
      counter         <= '0;
      sign_q          <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      cmdMultiplicand <= CMD_HOLD;
      cmdMultiplier   <= CMD_HOLD;
      cmdProduct      <= CMD_HOLD;
    end else begin
      state           <= next_state;
      cmdMultiplicand <= cmd_mc_d;
      cmdMultiplier   <= cmd_mp_d;
      cmdProduct      <= cmd_pr_d;
      if (state == S_IDLE && start) begin
        op_a_q  <= operandA;
        op_b_q  <= operandB;
        sign_q  <= operandA[OPERAND_WIDTH-1] ^ operandB[OPERAND_WIDTH-1];
        counter <= '0;
      end else if (state == S_SHIFT && next_state == S_TEST) begin
        counter <= counter + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer; models the three external registers acting on the falling edge.
module tb_mult_sequencer;
  localparam int W = 14;
`ifdef MULT_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] op_a = '0, op_b = '0;
  logic [27:0]         mc_reg = '0, mp_reg = '0, pr_reg = '0;
  logic [2:0]          cmd_mc, cmd_mp, cmd_pr;
  logic [27:0]         load_mc, load_mp, sum_out;
  logic                busy, done;

  int checks = 0;
  int errors = 0;
  int illegal_cmds = 0;

  mult_sequencer #(.OPERAND_WIDTH(W)) dut (
    .clockSequencer(clk), .resetSequencer(rst), .start(start),
    .operandA(op_a), .operandB(op_b),
    .multiplicandValue(mc_reg), .multiplierValue(mp_reg), .productValue(pr_reg),
    .cmdMultiplicand(cmd_mc), .cmdMultiplier(cmd_mp), .cmdProduct(cmd_pr),
    .loadMultiplicand(load_mc), .loadMultiplier(load_mp), .sumOut(sum_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External registers, driven only by the command codes.
  always @(negedge clk) begin
    case (cmd_mc)
      3'b001: mc_reg <= '0;
      3'b010: mc_reg <= load_mc;
      3'b011: mc_reg <= mc_reg << 1;
      3'b100: mc_reg <= mc_reg >> 1;
      default: ;
    endcase
    case (cmd_mp)
      3'b001: mp_reg <= '0;
      3'b010: mp_reg <= load_mp;
      3'b011: mp_reg <= mp_reg << 1;
      3'b100: mp_reg <= mp_reg >> 1;
      default: ;
    endcase
    case (cmd_pr)
      3'b001: pr_reg <= '0;
      3'b010: pr_reg <= sum_out;
      3'b011: pr_reg <= pr_reg << 1;
      3'b100: pr_reg <= pr_reg >> 1;
      default: ;
    endcase
    if (cmd_mc > 3'b100 || cmd_mp > 3'b100 || cmd_pr > 3'b100) illegal_cmds++;
  end

  task automatic test_reset;
    #3;
    checks++; if (cmd_mc !== 3'b000) begin errors++; $display("FAIL reset_cmd_mc got %b want 000", cmd_mc); end
    checks++; if (cmd_mp !== 3'b000) begin errors++; $display("FAIL reset_cmd_mp got %b want 000", cmd_mp); end
    checks++; if (cmd_pr !== 3'b000) begin errors++; $display("FAIL reset_cmd_pr got %b want 000", cmd_pr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done); end
    #20 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cmd_pr !== 3'b000) begin errors++; $display("FAIL idle_no_start got busy=%b cmd_pr=%b want 0 000", busy, cmd_pr); end
  endtask

  // One multiply; operands are scrambled right after the latch edge.
  task automatic run_op(input string name, input int a, input int b, input int exp_p,
                        input int edge_full, input int edge_early, input bit exp_neg);
    logic [27:0] want;
    logic [2:0]  prev_cmd;
    logic [27:0] prev_sum;
    int          n, want_edge, busy_bad;
    bit          got;
    want      = 28'(exp_p);
    want_edge = EARLY ? edge_early : edge_full;
    @(posedge clk); #1;
    start = 1'b1; op_a = W'(a); op_b = W'(b);
    @(posedge clk); #1;
    start = 1'b0; op_a = 14'sh1555; op_b = 14'sh2AAA;
    n = 0; got = 1'b0; busy_bad = 0; prev_cmd = '0; prev_sum = '0;
    while (!got && n < 200) begin
      if (!busy) busy_bad++;
      prev_cmd = cmd_pr; prev_sum = sum_out;
      @(posedge clk); #1;
      n++;
      got = done;
    end
    checks++; if (!got) begin errors++; $display("FAIL %s timeout no done after %0d edges", name, n); end
    checks++; if (n != want_edge) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, want_edge); end
    checks++; if (pr_reg !== want) begin errors++; $display("FAIL %s product got %0d want %0d", name, $signed(pr_reg), $signed(want)); end
    checks++; if (busy !== 1'b1 || busy_bad != 0) begin errors++; $display("FAIL %s busy got %b gaps=%0d want 1 0", name, busy, busy_bad); end
    checks++; if (prev_cmd !== (exp_neg ? 3'b010 : 3'b000)) begin errors++; $display("FAIL %s sign_cmd got %b want %b", name, prev_cmd, exp_neg ? 3'b010 : 3'b000); end
    if (exp_neg) begin
      checks++; if (prev_sum !== want) begin errors++; $display("FAIL %s sign_sum got %0d want %0d", name, $signed(prev_sum), $signed(want)); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy); end
  endtask

  task automatic test_basic;
    run_op("a3_b5",        3,     5,     15,        32, 11, 1'b0);
    run_op("am7_b6",      -7,     6,    -42,        32, 11, 1'b1);
    run_op("min_min",  -8192, -8192,  67108864,     31, 31, 1'b0);
    run_op("min_max",  -8192,  8191, -67100672,     43, 42, 1'b1);
    run_op("a123_b0",    123,     0,      0,        30,  3, 1'b0);
  endtask

  task automatic test_reset_mid_op;
    @(posedge clk); #1;
    start = 1'b1; op_a = 14'sd5; op_b = 14'sd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (cmd_pr !== 3'b010) begin errors++; $display("FAIL mid_in_add got cmd_pr=%b want 010", cmd_pr); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({cmd_mc, cmd_mp, cmd_pr} !== 9'd0) begin errors++; $display("FAIL mid_reset_cmds got %b %b %b want 000 000 000", cmd_mc, cmd_mp, cmd_pr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got busy=%b done=%b want 0 0", busy, done); end
    #4 rst = 1'b0;
    run_op("after_reset_a2_b2", 2, 2, 4, 31, 8, 1'b0);
  endtask

  task automatic test_back_to_back;
    int pulses, first;
    logic [27:0] prod;
    pulses = 0; first = 0; prod = '0;
    @(posedge clk); #1;
    start = 1'b1; op_a = 14'sd3; op_b = 14'sd5;
    @(posedge clk); #1;
    start = 1'b0; op_a = 14'sd100; op_b = -14'sd100;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) start = 1'b1;
      if (i == 8) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) begin first = i; prod = pr_reg; end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (first != (EARLY ? 11 : 32)) begin errors++; $display("FAIL b2b_latency got %0d want %0d", first, EARLY ? 11 : 32); end
    checks++; if (prod !== 28'd15) begin errors++; $display("FAIL b2b_product got %0d want 15", prod); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_op();
    test_back_to_back();
    checks++; if (illegal_cmds != 0) begin errors++; $display("FAIL illegal_cmd_codes got %0d want 0", illegal_cmds); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: OPERAND_WIDTH, default 14, signed operand width; SHALL satisfy 2*OPERAND_WIDTH <= 28.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clockSequencer  in  1  single clock; all state updates on rising edge.
  resetSequencer  in  1  asynchronous, active-high reset.
  start  in  1  request a multiply; sampled only in IDLE.
  operandA  in  OPERAND_WIDTH  signed multiplicand.
  operandB  in  OPERAND_WIDTH  signed multiplier.
  multiplicandValue  in  28  current value of the multiplicand register.
  multiplierValue  in  28  current value of the multiplier register.
  productValue  in  28  current value of the product register.
  cmdMultiplicand  out  3  command to the multiplicand register.
  cmdMultiplier  out  3  command to the multiplier register.
  cmdProduct  out  3  command to the product register.
  loadMultiplicand  out  28  zero-extended |operandA|, driven to the multiplicand register input.
  loadMultiplier  out  28  zero-extended |operandB|, driven to the multiplier register input.
  sumOut  out  28  product register input.
  busy  out  1  high from LOAD through DONE inclusive.
  done  out  1  one-cycle pulse; productValue holds the final signed result.
REQ-003 Command encoding SHALL be HOLD=000, RESET=001, LOAD=010, ShiftLeft=011, ShiftRight=100; codes 101-111 SHALL never be driven.
REQ-004 Command outputs SHALL be registered, changing only on the rising edge, so they are stable at the negative edge where the downstream registers act.

Function
REQ-005 States: IDLE, LOAD, TEST, ADD, SHIFT, SIGN, DONE; a 4-bit iteration counter.
REQ-006 IDLE: all commands HOLD; start=1 latches operandA, operandB and sign = A[msb]^B[msb], then moves to LOAD; start=0 stays.
REQ-007 LOAD: cmdMultiplicand=LOAD, cmdMultiplier=LOAD, cmdProduct=RESET; counter=0; next state TEST.
REQ-008 Magnitudes SHALL be computed from the latched operands; |-2^(OPERAND_WIDTH-1)| = 2^(OPERAND_WIDTH-1), unsigned, with no overflow.
REQ-009 TEST: all commands HOLD; multiplierValue[0]=1 -> ADD, else -> SHIFT.
REQ-010 ADD: cmdProduct=LOAD; sumOut = productValue + multiplicandValue (28-bit, wraps); next state SHIFT.
REQ-011 SHIFT: cmdMultiplicand=ShiftLeft, cmdMultiplier=ShiftRight; counter=OPERAND_WIDTH-1 -> SIGN, else counter+1 -> TEST.
REQ-012 SIGN: sign=1 -> cmdProduct=LOAD with sumOut = 0 - productValue; sign=0 -> HOLD; next state DONE.
REQ-013 DONE: all commands HOLD, done=1 for exactly one cycle; next state IDLE.
REQ-014 Latency: done SHALL assert in the cycle beginning 2*OPERAND_WIDTH+2+k rising edges after the edge that samples start, where k = popcount(|operandB|).
REQ-015 start while busy SHALL be ignored; operandA and operandB changes after the latch SHALL have no effect.
REQ-016 In IDLE, TEST, SHIFT and DONE, sumOut SHALL equal productValue + multiplicandValue.

Reset
REQ-017 resetSequencer=1 SHALL immediately force IDLE, counter=0, sign=0, all commands HOLD, busy=0 and done=0, including in mid-operation.
REQ-018 After reset deasserts, the first start SHALL begin a clean operation; a partial product left in the registers SHALL be cleared by the LOAD state.

Configuration
REQ-019 Macro MULT_SEQ_EARLY_EXIT_EN defined: in TEST, multiplierValue==0 SHALL go directly to SIGN, skipping the remaining iterations.
REQ-020 Macro MULT_SEQ_EARLY_EXIT_EN undefined: exactly OPERAND_WIDTH iterations always run, and REQ-014 latency holds.

Verification
REQ-021 A=3, B=5 -> product 15; done at edge 32 after start.
REQ-022 A=-7, B=6 -> product -42; SIGN state drives cmdProduct=LOAD with sumOut=-42.
REQ-023 A=-8192, B=-8192 -> product 67108864; sign=0; no overflow.
REQ-024 A=123, B=0 -> product 0; done at edge 30 without the macro, at edge 3 with MULT_SEQ_EARLY_EXIT_EN.
REQ-025 resetSequencer pulsed during ADD -> commands go to 000 and busy drops to 0 with no clock edge; a following A=2, B=2 run gives 4.
REQ-026 start pulsed with new operands while busy -> ignored; the first result completes unchanged and done pulses once.
